// File: rtl/score_fill_ctrl.sv
// score_fill_ctrl: sequencer that fills the Needleman-Wunsch score matrix in Scores_RAM.
// On start it writes the gap-penalty border (row 0 and column 0). It then visits every
// interior cell row-major: read diag/up/left, take the max of the three candidates,
// and write the result back. The last cell's score is kept on final_score.
//
// Optional feature macro: LEFT_FWD_EN. When defined, the left neighbour is forwarded
// from the previous write (or from i*GAP in column 1), so each cell takes 4 cycles
// instead of 5. RAM contents are the same either way.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             one-cycle request, sampled only while idle
//   match             character-compare result for the current i_idx/j_idx
//   i_idx, j_idx      current row-1 / column-1
//   ram_dout          Scores_RAM read data (valid the cycle after a read enable)
//   ram_din, ram_en_din, ram_we, ram_addr_din   write port
//   ram_en_dout, ram_addr_dout                  read port
//   busy, done, final_score                     status and result
module score_fill_ctrl #(
    parameter int N        = 5,
    parameter int ADDR_W   = $clog2(((N+1)*(N+1))-1)+1,
    parameter int GAP      = -2,
    parameter int MATCH    = 1,
    parameter int MISMATCH = -1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    match,
    output logic [$clog2(N):0]      i_idx,
    output logic [$clog2(N):0]      j_idx,
    input  logic signed [8:0]       ram_dout,
    output logic signed [8:0]       ram_din,
    output logic                    ram_en_din,
    output logic                    ram_we,
    output logic [ADDR_W-1:0]       ram_addr_din,
    output logic                    ram_en_dout,
    output logic [ADDR_W-1:0]       ram_addr_dout,
    output logic                    busy,
    output logic                    done,
    output logic signed [8:0]       final_score
);

    localparam int unsigned IW = $clog2(N) + 1;
    localparam int unsigned CW = $clog2(2*N + 1) + 1;

    localparam logic signed [9:0]  GAP10      = 10'(GAP);
    localparam logic signed [9:0]  MATCH10    = 10'(MATCH);
    localparam logic signed [9:0]  MISMATCH10 = 10'(MISMATCH);
    localparam logic signed [19:0] GAP20      = 20'(GAP);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_RD_D = 3'd2;
    localparam logic [2:0] S_RD_U = 3'd3;
    localparam logic [2:0] S_RD_L = 3'd4;
    localparam logic [2:0] S_CALC = 3'd5;
    localparam logic [2:0] S_WR   = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    // Row-major matrix address of (r, c), both in 0..N.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [IW-1:0] r,
                                                    input logic [IW-1:0] c);
        cell_addr = ADDR_W'(r) * ADDR_W'(N + 1) + ADDR_W'(c);
    endfunction

    // Clamp a 10-bit sum to the 9-bit signed range.
    function automatic logic signed [8:0] sat10(input logic signed [9:0] x);
        if (x > 10'sd255)       sat10 = 9'sh0FF;
        else if (x < -10'sd256) sat10 = 9'sh100;
        else                    sat10 = x[8:0];
    endfunction

    // Border value k*GAP, clamped to the 9-bit signed range.
    function automatic logic signed [8:0] border(input logic [IW-1:0] k);
        logic signed [19:0] p;
        p = $signed(20'(k)) * GAP20;
        if (p > 20'sd255)       border = 9'sh0FF;
        else if (p < -20'sd256) border = 9'sh100;
        else                    border = p[8:0];
    endfunction

    logic [2:0]          state, state_nxt;
    logic [CW-1:0]       cnt_q, cnt_nxt;
    logic [IW-1:0]       i_nxt, j_nxt;
    logic [IW-1:0]       bidx;
    logic signed [8:0]   diag_q, score_q;
`ifndef LEFT_FWD_EN
    logic signed [8:0]   up_q;
`endif

    logic signed [8:0]   din_nxt, final_nxt;
    logic                wr_nxt, rd_nxt, busy_nxt, done_nxt;
    logic [ADDR_W-1:0]   addr_din_nxt, addr_dout_nxt;

    logic signed [8:0]   up_src, left_src;
    logic signed [9:0]   s10, u10, l10;
    logic signed [8:0]   s9, u9, l9, best;

    // Cell score from the latched neighbours and the current match flag.
    always_comb begin
`ifdef LEFT_FWD_EN
        up_src   = ram_dout;
        left_src = (j_idx == '0) ? border(IW'(i_idx + IW'(1))) : score_q;
`else
        up_src   = up_q;
        left_src = ram_dout;
`endif
        s10  = $signed({diag_q[8], diag_q}) + (match ? MATCH10 : MISMATCH10);
        u10  = $signed({up_src[8], up_src}) + GAP10;
        l10  = $signed({left_src[8], left_src}) + GAP10;
        s9   = sat10(s10);
        u9   = sat10(u10);
        l9   = sat10(l10);
        best = s9;
        if (u9 > best) best = u9;
        if (l9 > best) best = l9;
    end

    // Next state, counters, and next values of the registered outputs.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt_q;
        i_nxt         = i_idx;
        j_nxt         = j_idx;
        bidx          = '0;
        din_nxt       = '0;
        wr_nxt        = 1'b0;
        rd_nxt        = 1'b0;
        addr_din_nxt  = '0;
        addr_dout_nxt = '0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        final_nxt     = final_score;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_INIT;
                    cnt_nxt   = '0;
                end
            end
            S_INIT: begin
                if (cnt_q == CW'(2*N)) begin
                    state_nxt = S_RD_D;
                    i_nxt     = '0;
                    j_nxt     = '0;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            S_RD_D: state_nxt = S_RD_U;
`ifdef LEFT_FWD_EN
            S_RD_U: state_nxt = S_CALC;
`else
            S_RD_U: state_nxt = S_RD_L;
`endif
            S_RD_L: state_nxt = S_CALC;
            S_CALC: state_nxt = S_WR;
            S_WR: begin
                if (j_idx < IW'(N - 1)) begin
                    state_nxt = S_RD_D;
                    j_nxt     = IW'(j_idx + IW'(1));
                end else if (i_idx < IW'(N - 1)) begin
                    state_nxt = S_RD_D;
                    i_nxt     = IW'(i_idx + IW'(1));
                    j_nxt     = '0;
                end else begin
                    state_nxt = S_DONE;
                    i_nxt     = '0;
                    j_nxt     = '0;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        case (state_nxt)
            S_INIT: begin
                busy_nxt = 1'b1;
                wr_nxt   = 1'b1;
                if (cnt_nxt == '0) begin
                    addr_din_nxt = '0;
                    din_nxt      = '0;
                end else if (cnt_nxt <= CW'(N)) begin
                    bidx         = IW'(cnt_nxt);
                    addr_din_nxt = cell_addr('0, bidx);
                    din_nxt      = border(bidx);
                end else begin
                    bidx         = IW'(cnt_nxt - CW'(N));
                    addr_din_nxt = cell_addr(bidx, '0);
                    din_nxt      = border(bidx);
                end
            end
            S_RD_D: begin
                busy_nxt      = 1'b1;
                rd_nxt        = 1'b1;
                addr_dout_nxt = cell_addr(i_nxt, j_nxt);
            end
            S_RD_U: begin
                busy_nxt      = 1'b1;
                rd_nxt        = 1'b1;
                addr_dout_nxt = cell_addr(i_nxt, IW'(j_nxt + IW'(1)));
            end
            S_RD_L: begin
                busy_nxt      = 1'b1;
                rd_nxt        = 1'b1;
                addr_dout_nxt = cell_addr(IW'(i_nxt + IW'(1)), j_nxt);
            end
            S_CALC: busy_nxt = 1'b1;
            S_WR: begin
                busy_nxt     = 1'b1;
                wr_nxt       = 1'b1;
                addr_din_nxt = cell_addr(IW'(i_nxt + IW'(1)), IW'(j_nxt + IW'(1)));
                din_nxt      = best;
            end
            S_DONE: begin
                done_nxt  = 1'b1;
                final_nxt = score_q;
            end
            default: ;
        endcase
    end

    // State, counters, neighbour latches and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt_q         <= '0;
            i_idx         <= '0;
            j_idx         <= '0;
            diag_q        <= '0;
            score_q       <= '0;
`ifndef LEFT_FWD_EN
            up_q          <= '0;
`endif
            ram_din       <= '0;
            ram_en_din    <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr_din  <= '0;
            ram_en_dout   <= 1'b0;
            ram_addr_dout <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            final_score   <= '0;
        end else begin
            state         <= state_nxt;
            cnt_q         <= cnt_nxt;
            i_idx         <= i_nxt;
            j_idx         <= j_nxt;
            ram_din       <= din_nxt;
            ram_en_din    <= wr_nxt;
            ram_we        <= wr_nxt;
            ram_addr_din  <= addr_din_nxt;
            ram_en_dout   <= rd_nxt;
            ram_addr_dout <= addr_dout_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            final_score   <= final_nxt;
            // Read data arrives one cycle after its read state.
            if (state == S_RD_U) diag_q <= ram_dout;
`ifndef LEFT_FWD_EN
            if (state == S_RD_L) up_q <= ram_dout;
`endif
            if (state == S_CALC) score_q <= best;
        end
    end

endmodule

// File: tb/tb_score_fill_ctrl.sv
// Bench for score_fill_ctrl: RAM model, randomized sequences, and a cycle-by-cycle
// schedule model derived from the Needleman-Wunsch recurrence and cycle budget.
module tb_score_fill_ctrl;

    localparam int N  = 5;
    localparam int NN = N + 1;
    localparam int AW = 7;
`ifdef LEFT_FWD_EN
    localparam int P        = 4;
    localparam int DONE_LIT = 112;
`else
    localparam int P        = 5;
    localparam int DONE_LIT = 137;
`endif
    localparam int FILL_END = 2*N + 1 + P*N*N;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    wire                match;
    logic [3:0]         i_idx, j_idx;
    logic signed [8:0]  ram_dout;
    logic signed [8:0]  ram_din;
    logic               ram_en_din, ram_we, ram_en_dout;
    logic [AW-1:0]      ram_addr_din, ram_addr_dout;
    logic               busy, done;
    logic signed [8:0]  final_score;

    score_fill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .match        (match),
        .i_idx        (i_idx),
        .j_idx        (j_idx),
        .ram_dout     (ram_dout),
        .ram_din      (ram_din),
        .ram_en_din   (ram_en_din),
        .ram_we       (ram_we),
        .ram_addr_din (ram_addr_din),
        .ram_en_dout  (ram_en_dout),
        .ram_addr_dout(ram_addr_dout),
        .busy         (busy),
        .done         (done),
        .final_score  (final_score)
    );

    always #5 clk = ~clk;

    // Scores_RAM model: synchronous read, write on enabled edge, optional scrub.
    logic signed [8:0] mem [0:NN*NN-1];
    bit scrub = 1'b0;
    always @(posedge clk) begin
        if (scrub) begin
            for (int k = 0; k < NN*NN; k++) mem[k] <= 9'sh100;
        end else if (ram_en_din && ram_we) begin
            mem[ram_addr_din] <= ram_din;
        end
        if (ram_en_dout) ram_dout <= mem[ram_addr_dout];
    end

    // Character-compare emulation.
    int mode = 0;
    logic [1:0] seqa [0:7];
    logic [1:0] seqb [0:7];
    assign match = (mode == 0) ? 1'b1 :
                   (mode == 1) ? 1'b0 :
                   (seqa[i_idx[2:0]] == seqb[j_idx[2:0]]);

    int vectors = 0;
    int errors  = 0;

    // Reference matrix and border write order.
    int M [0:N][0:N];
    int waddr [0:2*N];
    int wdata [0:2*N];

    function automatic int sat(input int x);
        if (x > 255) return 255;
        if (x < -256) return -256;
        return x;
    endfunction

    function automatic bit mref(input int i, input int j);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'b0;
        return seqa[i-1] == seqb[j-1];
    endfunction

    task automatic build_model();
        int s, u, l, b;
        M[0][0] = 0;
        waddr[0] = 0;
        wdata[0] = 0;
        for (int j = 1; j <= N; j++) begin
            M[0][j] = sat(j * -2);
            waddr[j] = j;
            wdata[j] = M[0][j];
        end
        for (int i = 1; i <= N; i++) begin
            M[i][0] = sat(i * -2);
            waddr[N+i] = i * NN;
            wdata[N+i] = M[i][0];
        end
        for (int i = 1; i <= N; i++) begin
            for (int j = 1; j <= N; j++) begin
                s = sat(M[i-1][j-1] + (mref(i, j) ? 1 : -1));
                u = sat(M[i-1][j] - 2);
                l = sat(M[i][j-1] - 2);
                b = s;
                if (u > b) b = u;
                if (l > b) b = l;
                M[i][j] = b;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle compare against the schedule model.
    bit run_active = 1'b0;
    int off = 0;
    int fin_exp = 0;
    int done_off_seen = -1;

    initial begin
        bit e_wr, e_rd, e_busy, e_done, chk_idx, chk_fin, ok;
        int e_aw, e_d, e_ar, e_i, e_j, e_fin, c, ph, ci, cj;
        string tag;
        forever begin
            @(negedge clk);
            e_wr = 0; e_rd = 0; e_busy = 0; e_done = 0; chk_idx = 0; chk_fin = 0;
            e_aw = 0; e_d = 0; e_ar = 0; e_i = 0; e_j = 0; e_fin = 0;
            tag = "idle";
            if (!rst) begin
                tag = "reset";
                run_active = 1'b0;
                fin_exp = 0;
                chk_idx = 1; chk_fin = 1;
            end else if (run_active) begin
                off++;
                e_busy = 1;
                if (done === 1'b1) done_off_seen = off;
                if (off <= 2*N + 1) begin
                    tag = "init";
                    e_wr = 1; e_aw = waddr[off-1]; e_d = wdata[off-1];
                end else if (off <= FILL_END) begin
                    tag = "fill";
                    c  = (off - 2*N - 2) / P;
                    ph = (off - 2*N - 2) % P;
                    ci = c / N + 1;
                    cj = c % N + 1;
                    chk_idx = 1; e_i = ci - 1; e_j = cj - 1;
                    if (ph == 0) begin
                        e_rd = 1; e_ar = (ci-1)*NN + cj - 1;
                    end else if (ph == 1) begin
                        e_rd = 1; e_ar = (ci-1)*NN + cj;
                    end else if (ph == P - 1) begin
                        e_wr = 1; e_aw = ci*NN + cj; e_d = M[ci][cj];
                    end else if (ph == 2 && P == 5) begin
                        e_rd = 1; e_ar = ci*NN + cj - 1;
                    end
                end else begin
                    tag = "done";
                    e_busy = 0; e_done = 1;
                    chk_fin = 1; e_fin = M[N][N];
                    fin_exp = M[N][N];
                    run_active = 1'b0;
                end
            end else begin
                chk_fin = 1; e_fin = fin_exp;
            end

            ok = (ram_en_din === e_wr) && (ram_we === e_wr) && (ram_en_dout === e_rd) &&
                 (busy === e_busy) && (done === e_done);
            if (e_wr)    ok = ok && (ram_addr_din === AW'(e_aw)) && (ram_din === 9'(e_d));
            if (e_rd)    ok = ok && (ram_addr_dout === AW'(e_ar));
            if (chk_idx) ok = ok && (i_idx === 4'(e_i)) && (j_idx === 4'(e_j));
            if (chk_fin) ok = ok && (final_score === 9'(e_fin));
            if (!rst)    ok = ok && (ram_din === 9'd0) && (ram_addr_din === '0) &&
                              (ram_addr_dout === '0);
            vectors++;
            if (!ok) begin
                errors++;
                $display("FAIL %s off=%0d: wr=%b/%b we=%b rd=%b/%b aw=%0d/%0d d=%0d/%0d ar=%0d/%0d busy=%b/%b done=%b/%b i=%0d/%0d j=%0d/%0d fin=%0d/%0d",
                         tag, off, ram_en_din, e_wr, ram_we, ram_en_dout, e_rd,
                         ram_addr_din, e_aw, ram_din, e_d, ram_addr_dout, e_ar,
                         busy, e_busy, done, e_done, i_idx, e_i, j_idx, e_j,
                         final_score, e_fin);
            end
        end
    end

    task automatic prepare(input int md);
        mode = md;
        for (int k = 0; k < 8; k++) begin
            seqa[k] = 2'($urandom_range(3, 0));
            seqb[k] = 2'($urandom_range(3, 0));
        end
        build_model();
        @(posedge clk); #1 scrub = 1'b1;
        @(posedge clk); #1 scrub = 1'b0;
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        off = 0;
        done_off_seen = -1;
        run_active = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (run_active && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (run_active) begin
            vectors++;
            errors++;
            $display("FAIL run_timeout: still active after %0d cycles, expected completion", n);
            run_active = 1'b0;
        end
        #1;
        for (int i = 0; i <= N; i++)
            for (int j = 0; j <= N; j++)
                chk($sformatf("mem[%0d][%0d]", i, j), int'(mem[i*NN+j]), M[i][j]);
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);

        // All characters match.
        prepare(0);
        chk("model_all_match_M11", M[1][1], 1);
        do_start();
        wait_idle();
        chk("all_match_addr7", int'(mem[7]), 1);
        chk("all_match_addr35", int'(mem[35]), 5);
        chk("all_match_final", int'(final_score), 5);
        chk("all_match_done_cycle", done_off_seen, DONE_LIT);
        chk("border_addr5", int'(mem[5]), -10);
        chk("border_addr12", int'(mem[12]), -4);
        chk("border_addr30", int'(mem[30]), -10);

        // No characters match.
        prepare(1);
        do_start();
        wait_idle();
        chk("all_mismatch_addr7", int'(mem[7]), -1);
        chk("all_mismatch_addr35", int'(mem[35]), -5);
        chk("all_mismatch_final", int'(final_score), -5);

        // Second start while busy is ignored.
        prepare(2);
        do_start();
        repeat (49) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        chk("busy_start_final", int'(final_score), M[N][N]);

        // Abort mid-fill, then rerun.
        prepare(2);
        do_start();
        repeat (59) @(posedge clk);
        #1 rst = 1'b0;
        run_active = 1'b0;
        #1 chk("async_abort_outputs", int'({busy, done, ram_en_din, ram_we, ram_en_dout}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        prepare(2);
        do_start();
        wait_idle();
        chk("rerun_final", int'(final_score), M[N][N]);

        // Further random sequences.
        for (int r = 0; r < 3; r++) begin
            prepare(2);
            do_start();
            wait_idle();
            chk($sformatf("rand%0d_done_cycle", r), done_off_seen, DONE_LIT);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
